// File: rtl/simon_cfg_ctrl.sv
// Simon128/128 configuration slave: AXI4-Lite register file plus key-load/start/done sequencer.
// Latency: bresp and rdata one cycle after acceptance; key_load_o/start_o one or two cycles after START.
// Backpressure: one outstanding write and one outstanding read; a held bvalid/rvalid stalls the next request.
module simon_cfg_ctrl #(
    parameter int CFG_ADDR_WIDTH = 32,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int CFG_RESP_WIDTH = 2,
    parameter int CFG_STRB_WIDTH = 4,
    parameter int KEY_WIDTH      = 128,
    parameter int TIMEOUT        = 1024
) (
    input  logic                      clk_simon_cfg,
    input  logic                      rst_simon_cfg,
    input  logic [CFG_ADDR_WIDTH-1:0] simon_cfg_awaddr,
    input  logic [2:0]                simon_cfg_awprot,
    input  logic                      simon_cfg_awvalid,
    output logic                      simon_cfg_awready,
    input  logic [CFG_DATA_WIDTH-1:0] simon_cfg_wdata,
    input  logic [CFG_STRB_WIDTH-1:0] simon_cfg_wstrb,
    input  logic                      simon_cfg_wvalid,
    output logic                      simon_cfg_wready,
    output logic [CFG_RESP_WIDTH-1:0] simon_cfg_bresp,
    output logic                      simon_cfg_bvalid,
    input  logic                      simon_cfg_bready,
    input  logic [CFG_ADDR_WIDTH-1:0] simon_cfg_araddr,
    input  logic [2:0]                simon_cfg_arprot,
    input  logic                      simon_cfg_arvalid,
    output logic                      simon_cfg_arready,
    output logic [CFG_DATA_WIDTH-1:0] simon_cfg_rdata,
    output logic [CFG_RESP_WIDTH-1:0] simon_cfg_rresp,
    output logic                      simon_cfg_rvalid,
    input  logic                      simon_cfg_rready,
    output logic [KEY_WIDTH-1:0]      key_o,
    output logic                      decrypt_o,
    output logic                      key_load_o,
    output logic                      start_o,
    input  logic                      core_done_i,
    output logic                      irq_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CFG_RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [CFG_RESP_WIDTH-1:0] RESP_SLVERR = CFG_RESP_WIDTH'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_KEYLD, ST_ISSUE, ST_RUN} state_t;

    state_t                    state_q, state_d;
    logic [TW-1:0]             timer_q;
    logic [CFG_DATA_WIDTH-1:0] key_q [4];
    logic [3:0]                key_written_q;
    logic                      key_dirty_q;
    logic                      decrypt_q, irq_en_q, done_q, tmo_q, irq_q;
    logic [31:0]               blk_count_q;

    logic                      busy, key_valid;
    logic                      wr_fire, rd_fire;
    logic [3:0]                wr_idx, rd_idx;
    logic                      wr_err, ctrl_sel, status_sel, key_sel;
    logic                      ctrl_wr, status_wr, key_wr;
    logic                      start_req, start_go, start_nokey, clr_req;
    logic                      run_done, run_tmo;
    logic [CFG_DATA_WIDTH-1:0] rd_data;
    logic                      rd_err;
    logic                      unused_bits;

    assign unused_bits = ^{simon_cfg_awprot, simon_cfg_arprot,
                           simon_cfg_awaddr[CFG_ADDR_WIDTH-1:6], simon_cfg_awaddr[1:0],
                           simon_cfg_araddr[CFG_ADDR_WIDTH-1:6], simon_cfg_araddr[1:0]};

    assign busy      = (state_q != ST_IDLE);
    assign key_valid = &key_written_q;
    assign wr_idx    = simon_cfg_awaddr[5:2];
    assign rd_idx    = simon_cfg_araddr[5:2];

    // AW and W are accepted together, only while no write response is pending
    assign wr_fire           = simon_cfg_awvalid & simon_cfg_wvalid & ~simon_cfg_bvalid;
    assign simon_cfg_awready = wr_fire;
    assign simon_cfg_wready  = wr_fire;
    assign rd_fire           = simon_cfg_arvalid & ~simon_cfg_rvalid;
    assign simon_cfg_arready = rd_fire;

    // Write address decode and rejection of writes that would disturb a running block
    always_comb begin
        wr_err     = 1'b0;
        ctrl_sel   = 1'b0;
        status_sel = 1'b0;
        key_sel    = 1'b0;
        case (wr_idx)
            4'h0: begin
                ctrl_sel = 1'b1;
                if (busy && simon_cfg_wstrb[0] && (simon_cfg_wdata[1] != decrypt_q)) wr_err = 1'b1;
            end
            4'h1: status_sel = 1'b1;
            4'h2: ;
            4'h4, 4'h5, 4'h6, 4'h7: begin
                if (busy) wr_err = 1'b1;
                else      key_sel = 1'b1;
            end
            default: wr_err = 1'b1;
        endcase
    end

    assign ctrl_wr     = wr_fire & ctrl_sel & simon_cfg_wstrb[0] & ~wr_err;
    assign status_wr   = wr_fire & status_sel & simon_cfg_wstrb[0];
    assign key_wr      = wr_fire & key_sel;
    assign start_req   = ctrl_wr & simon_cfg_wdata[0] & ~busy;
    assign start_go    = start_req & key_valid;
    assign start_nokey = start_req & ~key_valid;
    assign clr_req     = ctrl_wr & simon_cfg_wdata[3];

    // Sequencer next state and one-cycle pulses; core_done_i only matters in RUN
    always_comb begin
        state_d    = state_q;
        key_load_o = 1'b0;
        start_o    = 1'b0;
        run_done   = 1'b0;
        run_tmo    = 1'b0;
        case (state_q)
            ST_IDLE:  if (start_go) state_d = key_dirty_q ? ST_KEYLD : ST_ISSUE;
            ST_KEYLD: begin
                key_load_o = 1'b1;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                start_o = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (core_done_i) begin
                    run_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    run_tmo = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and completion timer (zeroed while start_o is issued)
    always_ff @(posedge clk_simon_cfg or posedge rst_simon_cfg) begin
        if (rst_simon_cfg) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ISSUE)    timer_q <= '0;
            else if (state_q == ST_RUN) timer_q <= timer_q + 1'b1;
        end
    end

    // Key words with byte strobes; written/dirty tracking drives KEY_VALID and the reload decision
    always_ff @(posedge clk_simon_cfg or posedge rst_simon_cfg) begin
        if (rst_simon_cfg) begin
            for (int w = 0; w < 4; w++) key_q[w] <= '0;
            key_written_q <= '0;
            key_dirty_q   <= 1'b0;
        end else begin
            if (key_wr) begin
                for (int b = 0; b < CFG_STRB_WIDTH; b++)
                    if (simon_cfg_wstrb[b]) key_q[wr_idx[1:0]][8*b +: 8] <= simon_cfg_wdata[8*b +: 8];
                key_written_q[wr_idx[1:0]] <= 1'b1;
                key_dirty_q                <= 1'b1;
            end else if (state_q == ST_KEYLD) begin
                key_dirty_q <= 1'b0;
            end
        end
    end

    // Control/status bits and block counter; a completion beats W1C, a CLR beats the increment
    always_ff @(posedge clk_simon_cfg or posedge rst_simon_cfg) begin
        if (rst_simon_cfg) begin
            decrypt_q   <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            blk_count_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                decrypt_q <= simon_cfg_wdata[1];
                irq_en_q  <= simon_cfg_wdata[2];
            end
            done_q <= run_done | (done_q & ~(status_wr & simon_cfg_wdata[1]));
            tmo_q  <= run_tmo | start_nokey | (tmo_q & ~(status_wr & simon_cfg_wdata[3]));
            if (clr_req)       blk_count_q <= '0;
            else if (run_done) blk_count_q <= blk_count_q + 32'd1;
            irq_q <= irq_en_q & (done_q | tmo_q);
        end
    end

    // Read data mux; unmapped offsets return zero with an error response
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            4'h0: rd_data[2:1] = {irq_en_q, decrypt_q};
            4'h1: rd_data[3:0] = {tmo_q, key_valid, done_q, busy};
            4'h2: rd_data = blk_count_q;
            4'h4, 4'h5, 4'h6, 4'h7: rd_data = key_q[rd_idx[1:0]];
            default: rd_err = 1'b1;
        endcase
    end

    // Response channels: data captured at acceptance and held until the master takes it
    always_ff @(posedge clk_simon_cfg or posedge rst_simon_cfg) begin
        if (rst_simon_cfg) begin
            simon_cfg_bvalid <= 1'b0;
            simon_cfg_bresp  <= RESP_OKAY;
            simon_cfg_rvalid <= 1'b0;
            simon_cfg_rresp  <= RESP_OKAY;
            simon_cfg_rdata  <= '0;
        end else begin
            if (wr_fire) begin
                simon_cfg_bvalid <= 1'b1;
                simon_cfg_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (simon_cfg_bready) begin
                simon_cfg_bvalid <= 1'b0;
            end
            if (rd_fire) begin
                simon_cfg_rvalid <= 1'b1;
                simon_cfg_rdata  <= rd_data;
                simon_cfg_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (simon_cfg_rready) begin
                simon_cfg_rvalid <= 1'b0;
            end
        end
    end

    assign key_o     = {key_q[3], key_q[2], key_q[1], key_q[0]};
    assign decrypt_o = decrypt_q;
    assign irq_o     = irq_q;

endmodule
